// File: rtl/mtm_alu_serializer.sv
// mtm_alu_serializer: frames the ALU result and control byte into 11-bit serial packets
module mtm_alu_serializer #(
    parameter int DATA_BYTES = 4,
    parameter int PKT_GAP    = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    data_valid,
    input  logic                    err,
    input  logic [8*DATA_BYTES-1:0] c_in,
    input  logic [7:0]              ctl_in,
    output logic                    sout,
    output logic                    busy,
    output logic                    done
);
    localparam int PW = $clog2(DATA_BYTES + 1);
    localparam logic [PW-1:0] LAST = PW'(DATA_BYTES);
    localparam logic [3:0] GAP_LAST = 4'(PKT_GAP - 1);

    typedef enum logic [2:0] {IDLE, START, TYPE, BITS, STOP, GAP} state_t;

    state_t                  r_state;
    logic [8*DATA_BYTES-1:0] r_data;
    logic [7:0]              r_ctl;
    logic [7:0]              r_shift;
    logic [PW-1:0]           r_pkt;
    logic [2:0]              r_bit;
    logic [3:0]              r_gap;
    logic                    r_sout;
    logic                    r_busy;
    logic                    r_done;
    logic                    w_cmd;

    // The CMD packet is always the last index; an error response jumps straight to it
    assign w_cmd = (r_pkt == LAST);
    assign sout  = r_sout;
    assign busy  = r_busy;
    assign done  = r_done;

    // Packet sequencer; sout/busy/done are registered alongside the state they describe
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_data  <= '0;
            r_ctl   <= '0;
            r_shift <= '0;
            r_pkt   <= '0;
            r_bit   <= '0;
            r_gap   <= '0;
            r_sout  <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_sout <= 1'b1;
                    if (data_valid) begin
                        r_data  <= c_in;
                        r_ctl   <= ctl_in;
                        r_pkt   <= err ? LAST : '0;
                        r_state <= START;
                        r_sout  <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                START: begin
                    r_state <= TYPE;
                    r_sout  <= w_cmd;
                    r_shift <= w_cmd ? r_ctl : r_data[8*DATA_BYTES-1 -: 8];
                    if (!w_cmd)
                        r_data <= r_data << 8;
                end
                TYPE: begin
                    r_state <= BITS;
                    r_bit   <= 3'd7;
                    r_sout  <= r_shift[7];
                end
                BITS: begin
                    if (r_bit == 3'd0) begin
                        r_state <= STOP;
                        r_sout  <= 1'b1;
                    end else begin
                        r_bit   <= r_bit - 3'd1;
                        r_shift <= r_shift << 1;
                        r_sout  <= r_shift[6];
                    end
                end
                STOP: begin
                    if (w_cmd) begin
                        r_state <= IDLE;
                        r_sout  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_pkt <= r_pkt + 1'b1;
                        if (PKT_GAP > 0) begin
                            r_state <= GAP;
                            r_gap   <= 4'd0;
                            r_sout  <= 1'b1;
                        end else begin
                            r_state <= START;
                            r_sout  <= 1'b0;
                        end
                    end
                end
                GAP: begin
                    if (r_gap == GAP_LAST) begin
                        r_state <= START;
                        r_sout  <= 1'b0;
                    end else begin
                        r_gap <= r_gap + 4'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_sout  <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule
